prog_load_check_ctrl: RTL and testbench

- Parametrised program-loader and result-checker controller for the pipelined RISC-V core.
- Holds the core in reset while it writes a program into instruction memory and initial values into the register file.
- Releases the core for a bounded number of cycles, then freezes it again.
- Sweeps the register file against an internally stored expected-value table and reports pass/fail, mismatch count and the first failing register.

---
 rtl/prog_load_check_ctrl_if.sv | 17 +
 rtl/prog_load_check_ctrl.sv | 157 +++++++++++++++
 tb/tb_prog_load_check_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_load_check_ctrl_if.sv
// Loader-side handshake bundle for prog_load_check_ctrl: valid/ready plus the
// entry kind, address and payload.
interface prog_load_check_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int IMEM_AW = 6
);
  logic               load_valid;
  logic               load_ready;
  logic [1:0]         load_kind;
  logic [IMEM_AW-1:0] load_addr;
  logic [XLEN-1:0]    load_data;

  modport master (output load_valid, load_kind, load_addr, load_data,
                  input  load_ready);
  modport slave  (input  load_valid, load_kind, load_addr, load_data,
                  output load_ready);
endinterface

// File: rtl/prog_load_check_ctrl.sv
// Program loader / result checker: loads imem and register file, runs the core
// for a bounded time, then sweeps the register file against an expected table.
// Optional feature macro: RUN_EARLY_HALT_EN (adds core_halt to end RUN early).
module prog_load_check_ctrl #(
  parameter int XLEN       = 32,
  parameter int IMEM_AW    = 6,
  parameter int REG_AW     = 5,
  parameter int RUN_CYCLES = 20
) (
  input  logic                clk,
  input  logic                reset,
  prog_load_check_ctrl_if.slave load,
  input  logic                start,
  input  logic                clear,
`ifdef RUN_EARLY_HALT_EN
  input  logic                core_halt,
`endif
  output logic                core_reset,
  output logic                imem_we,
  output logic [IMEM_AW-1:0]  imem_addr,
  output logic [XLEN-1:0]     imem_wdata,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  output logic [REG_AW-1:0]   rf_raddr,
  input  logic [XLEN-1:0]     rf_rdata,
  output logic                done,
  output logic                pass,
  output logic [REG_AW:0]     mismatch_count,
  output logic [REG_AW-1:0]   first_fail_reg
);

  localparam int NREGS = 1 << REG_AW;
  localparam int RUN_W = (RUN_CYCLES < 2) ? 1 : $clog2(RUN_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t              state;
  logic [RUN_W-1:0]    run_cnt;
  logic [REG_AW-1:0]   chk_idx;
  logic [NREGS-1:0]    exp_mask;
  logic [XLEN-1:0]     exp_tab [NREGS];
  logic [REG_AW-1:0]   load_idx;
  logic                load_fire;
  logic                halt_req;
  logic                run_end;
  logic                chk_fail;
  logic [REG_AW:0]     count_next;

`ifdef RUN_EARLY_HALT_EN
  assign halt_req = core_halt;
`else
  assign halt_req = 1'b0;
`endif

  assign load.load_ready = (state == IDLE);
  assign load_fire       = load.load_valid && (state == IDLE);
  assign load_idx        = load.load_addr[REG_AW-1:0];
  assign run_end         = (run_cnt == RUN_LAST) || halt_req;
  assign rf_raddr        = chk_idx;
  assign chk_fail        = exp_mask[chk_idx] && (rf_rdata != exp_tab[chk_idx]);
  assign count_next      = mismatch_count + {{REG_AW{1'b0}}, chk_fail};

  // Expected values carry no reset; the mask alone decides which entries count.
  always_ff @(posedge clk) begin
    if (load_fire && load.load_kind == 2'b10)
      exp_tab[load_idx] <= load.load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      core_reset     <= 1'b1;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      run_cnt        <= '0;
      chk_idx        <= '0;
      exp_mask       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail_reg <= '0;
    end else begin
      imem_we <= 1'b0;
      rf_we   <= 1'b0;
      case (state)
        IDLE: begin
          core_reset <= 1'b1;
          if (load_fire) begin
            case (load.load_kind)
              2'b00: begin
                imem_we    <= 1'b1;
                imem_addr  <= load.load_addr;
                imem_wdata <= load.load_data;
              end
              2'b01: begin
                rf_we    <= (load_idx != '0);
                rf_waddr <= load_idx;
                rf_wdata <= load.load_data;
              end
              2'b10:   exp_mask[load_idx] <= 1'b1;
              default: ;
            endcase
          end
          // A start that coincides with an offered entry is dropped on purpose.
          if (start && !load.load_valid) begin
            run_cnt <= '0;
            chk_idx <= '0;
            if (RUN_CYCLES == 0) begin
              state <= CHECK;
            end else begin
              state      <= RUN;
              core_reset <= 1'b0;
            end
          end
        end
        RUN: begin
          if (run_end) begin
            state      <= CHECK;
            core_reset <= 1'b1;
          end else if (run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        CHECK: begin
          mismatch_count <= count_next;
          if (chk_fail && mismatch_count == '0)
            first_fail_reg <= chk_idx;
          chk_idx <= chk_idx + 1'b1;
          if (chk_idx == '1) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (count_next == '0);
          end
        end
        DONE: begin
          if (clear) begin
            state          <= IDLE;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_reg <= '0;
            exp_mask       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_load_check_ctrl.sv
// Randomised self-checking bench for prog_load_check_ctrl with a register-file
// and toy-core model (x2 = x1 - x3, x5 = x4 + x3 while the core runs).
module tb_prog_load_check_ctrl;

  localparam int XLEN       = 32;
  localparam int IMEM_AW    = 6;
  localparam int REG_AW     = 5;
  localparam int RUN_CYCLES = 20;
  localparam int NREGS      = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic clear = 1'b0;
`ifdef RUN_EARLY_HALT_EN
  logic core_halt = 1'b0;
`endif
  logic               core_reset;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_wdata;
  logic               rf_we;
  logic [REG_AW-1:0]  rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic [REG_AW-1:0]  rf_raddr;
  logic [XLEN-1:0]    rf_rdata;
  logic               done;
  logic               pass;
  logic [REG_AW:0]    mismatch_count;
  logic [REG_AW-1:0]  first_fail_reg;

  logic [XLEN-1:0] rf_mem [NREGS];
  logic [XLEN-1:0] m_rf   [NREGS];
  logic [XLEN-1:0] m_exp  [NREGS];
  bit              m_mask [NREGS];

  int checks = 0;
  int errors = 0;

  prog_load_check_ctrl_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW)) lif ();

  prog_load_check_ctrl #(
    .XLEN(XLEN), .IMEM_AW(IMEM_AW), .REG_AW(REG_AW), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .load(lif), .start(start), .clear(clear),
`ifdef RUN_EARLY_HALT_EN
    .core_halt(core_halt),
`endif
    .core_reset(core_reset), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .first_fail_reg(first_fail_reg)
  );

  always #5 clk = ~clk;

  // Register file plus a toy core that only computes while out of reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_mem[i] <= '0;
    end else begin
      if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
      if (!core_reset) begin
        rf_mem[2] <= rf_mem[1] - rf_mem[3];
        rf_mem[5] <= rf_mem[4] + rf_mem[3];
      end
    end
  end
  assign rf_rdata = rf_mem[rf_raddr];

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_kind  = 2'b00;
    lif.load_addr  = '0;
    lif.load_data  = '0;
    for (int i = 0; i < NREGS; i++) begin
      m_rf[i] = '0; m_exp[i] = '0; m_mask[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Offers one entry (valid left high so callers can chain entries) and checks the write pulse.
  task automatic load_entry(input logic [1:0] k, input logic [IMEM_AW-1:0] a,
                            input logic [XLEN-1:0] d);
    int  idx;
    logic exp_imem, exp_rf;
    idx = int'(a[REG_AW-1:0]);
    checks++;
    if (lif.load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_ready: got %b expected 1", lif.load_ready);
    end
    lif.load_valid = 1'b1;
    lif.load_kind  = k;
    lif.load_addr  = a;
    lif.load_data  = d;
    @(posedge clk);
    @(negedge clk);
    exp_imem = (k == 2'b00);
    exp_rf   = (k == 2'b01) && (idx != 0);
    checks++;
    if (imem_we !== exp_imem || rf_we !== exp_rf) begin
      errors++;
      $display("[TB] FAIL write_pulse kind=%0d addr=%0d: got imem_we=%b rf_we=%b expected %b %b",
               k, a, imem_we, rf_we, exp_imem, exp_rf);
    end
    if (exp_imem) begin
      checks++;
      if (imem_addr !== a || imem_wdata !== d) begin
        errors++;
        $display("[TB] FAIL imem_port: got addr=%0d data=%h expected %0d %h",
                 imem_addr, imem_wdata, a, d);
      end
    end
    if (exp_rf) begin
      checks++;
      if (rf_waddr !== a[REG_AW-1:0] || rf_wdata !== d) begin
        errors++;
        $display("[TB] FAIL rf_port: got addr=%0d data=%h expected %0d %h",
                 rf_waddr, rf_wdata, idx, d);
      end
    end
    if (exp_rf) m_rf[idx] = d;
    if (k == 2'b10) begin
      m_exp[idx]  = d;
      m_mask[idx] = 1'b1;
    end
  endtask

  // Starts a run (optionally halted early), waits for done, checks timing, result, hold and clear.
  task automatic run_and_check(input int halt_at, input string name);
    int cyc, low, first_low, last_low, run_len, e_cnt, e_first;
    bit got;
    run_len = (halt_at > 0 && halt_at < RUN_CYCLES) ? halt_at : RUN_CYCLES;
    lif.load_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; low = 0; first_low = -1; last_low = -1; got = 1'b0;
    while (cyc <= 400) begin
      if (core_reset === 1'b0) begin
        low++;
        if (first_low < 0) first_low = cyc;
        last_low = cyc;
      end
`ifdef RUN_EARLY_HALT_EN
      core_halt = (cyc == halt_at);
`endif
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
`ifdef RUN_EARLY_HALT_EN
    core_halt = 1'b0;
`endif
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL %s done_timeout: got no done after %0d cycles expected %0d", name, cyc, run_len + NREGS + 1);
      return;
    end
    checks++;
    if (cyc != run_len + NREGS + 1) begin
      errors++;
      $display("[TB] FAIL %s done_latency: got %0d expected %0d", name, cyc, run_len + NREGS + 1);
    end
    checks++;
    if (low != run_len || first_low != 1 || last_low != run_len) begin
      errors++;
      $display("[TB] FAIL %s core_reset_low: got %0d cycles (%0d..%0d) expected %0d (1..%0d)",
               name, low, first_low, last_low, run_len, run_len);
    end
    m_rf[2] = m_rf[1] - m_rf[3];
    m_rf[5] = m_rf[4] + m_rf[3];
    e_cnt = 0; e_first = 0;
    for (int i = 0; i < NREGS; i++) begin
      if (m_mask[i] && m_rf[i] != m_exp[i]) begin
        if (e_cnt == 0) e_first = i;
        e_cnt++;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== (e_cnt == 0) || mismatch_count !== 6'(e_cnt) ||
        first_fail_reg !== 5'(e_first) || core_reset !== 1'b1 || lif.load_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s result: got done=%b pass=%b cnt=%0d first=%0d core_reset=%b ready=%b expected 1 %b %0d %0d 1 0",
               name, done, pass, mismatch_count, first_fail_reg, core_reset, lif.load_ready,
               e_cnt == 0, e_cnt, e_first);
    end
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < NREGS; i++) m_mask[i] = 1'b0;
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || mismatch_count !== '0 ||
        first_fail_reg !== '0 || lif.load_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s clear: got done=%b pass=%b cnt=%0d first=%0d ready=%b expected 0 0 0 0 1",
               name, done, pass, mismatch_count, first_fail_reg, lif.load_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (core_reset !== 1'b1 || lif.load_ready !== 1'b1 || done !== 1'b0 || pass !== 1'b0 ||
        mismatch_count !== '0 || first_fail_reg !== '0 || imem_we !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got core_reset=%b ready=%b done=%b pass=%b cnt=%0d first=%0d imem_we=%b rf_we=%b",
               core_reset, lif.load_ready, done, pass, mismatch_count, first_fail_reg, imem_we, rf_we);
    end
  endtask

  task automatic load_program(input logic [XLEN-1:0] exp_x2, input bit use_x5);
    for (int i = 0; i < 8; i++) load_entry(2'b00, IMEM_AW'(i), $urandom);
    load_entry(2'b01, 6'd1, 32'd20);
    load_entry(2'b01, 6'd3, 32'd5);
    load_entry(2'b01, 6'd4, 32'd10);
    load_entry(2'b10, 6'd2, exp_x2);
    if (use_x5) load_entry(2'b10, 6'd5, 32'd12);
    lif.load_valid = 1'b0;
  endtask

  task automatic test_program_pass();
    do_reset();
    load_program(32'd15, 1'b0);
    run_and_check(0, "program_pass");
  endtask

  task automatic test_single_fail();
    do_reset();
    load_program(32'd16, 1'b0);
    run_and_check(0, "single_fail");
  endtask

  task automatic test_double_fail();
    do_reset();
    load_program(32'd16, 1'b1);
    run_and_check(0, "double_fail");
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_entry(2'b01, 6'd0, 32'd7);
    load_entry(2'b00, 6'd63, 32'hDEAD_BEEF);
    load_entry(2'b11, 6'd9, 32'h1234_5678);
    load_entry(2'b01, 6'd33, 32'hA5A5_0001);
    load_entry(2'b10, 6'd7, 32'd0);
    load_entry(2'b10, 6'd7, 32'd3);
    lif.load_valid = 1'b0;
    run_and_check(0, "back_to_back");
  endtask

  task automatic test_start_ignored();
    do_reset();
    lif.load_valid = 1'b1;
    lif.load_kind  = 2'b11;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lif.load_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (core_reset !== 1'b1 || lif.load_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_with_valid: got core_reset=%b ready=%b done=%b expected 1 1 0",
               core_reset, lif.load_ready, done);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_entry(2'b10, 6'd2, 32'd16);
    load_entry(2'b10, 6'd7, 32'd99);
    lif.load_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (core_reset !== 1'b1 || lif.load_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run_async: got core_reset=%b ready=%b done=%b expected 1 1 0",
               core_reset, lif.load_ready, done);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      m_rf[i] = '0; m_mask[i] = 1'b0;
    end
    checks++;
    if (core_reset !== 1'b1 || lif.load_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run_idle: got core_reset=%b ready=%b done=%b expected 1 1 0",
               core_reset, lif.load_ready, done);
    end
    run_and_check(0, "after_abort");
  endtask

  task automatic test_random();
    logic [1:0] k;
    int n;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(16, 4);
      for (int e = 0; e < n; e++) begin
        k = 2'($urandom_range(3, 0));
        if (k == 2'b00)
          load_entry(k, IMEM_AW'($urandom_range(63, 0)), $urandom);
        else
          load_entry(k, IMEM_AW'($urandom_range(7, 0) + 32 * $urandom_range(1, 0)),
                     XLEN'($urandom_range(3, 0)));
      end
      lif.load_valid = 1'b0;
      run_and_check(0, "random");
    end
  endtask

`ifdef RUN_EARLY_HALT_EN
  task automatic test_early_halt();
    do_reset();
    load_program(32'd15, 1'b0);
    run_and_check(3, "early_halt");
  endtask
`endif

  initial begin
    test_reset();
    test_program_pass();
    test_single_fail();
    test_double_fail();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
`ifdef RUN_EARLY_HALT_EN
    test_early_halt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
